// File: rtl/cr16_datapath.sv
// CR16 datapath: sixteen 16-bit registers, operand muxes, ALU and 5-bit status register.
// Define CR16_DATAPATH_MUL_EN to build the multiplier for opcode 6; otherwise opcode 6 yields 0.
module cr16_datapath (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_ENABLE,
    input  logic [15:0] I_REG_WRITE_ENABLE,
    input  logic [3:0]  I_REG_A_SELECT,
    input  logic [3:0]  I_REG_B_SELECT,
    input  logic        I_IMMEDIATE_SELECT,
    input  logic [15:0] I_IMMEDIATE,
    input  logic [3:0]  I_OPCODE,
    input  logic [4:0]  I_STATUS_FLAGS,
    input  logic        I_STATUS_FLAGS_SELECT,
    input  logic [15:0] I_REGFILE_DATA,
    input  logic        I_REGFILE_DATA_SELECT,
    output logic [15:0] O_A,
    output logic [15:0] O_B,
    output logic [15:0] O_RESULT_BUS,
    output logic [4:0]  O_STATUS_FLAGS
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDU  = 4'd1,
        OP_ADDC  = 4'd2,
        OP_ADDCU = 4'd3,
        OP_SUB   = 4'd4,
        OP_SUBU  = 4'd5,
        OP_MUL   = 4'd6,
        OP_AND   = 4'd7,
        OP_OR    = 4'd8,
        OP_XOR   = 4'd9,
        OP_NOT   = 4'd10,
        OP_LSH   = 4'd11,
        OP_RSH   = 4'd12,
        OP_ALSH  = 4'd13,
        OP_ARSH  = 4'd14,
        OP_PASS  = 4'd15
    } op_e;

    logic [15:0] r_regs [16];
    logic [4:0]  r_flags;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_alu;
    logic [15:0] w_result;
    logic [16:0] w_sum;
    logic        w_c;
    logic        w_l;
    logic        w_f;
    logic [4:0]  w_flags;

    assign w_a = r_regs[I_REG_A_SELECT];
    assign w_b = I_IMMEDIATE_SELECT ? I_IMMEDIATE : r_regs[I_REG_B_SELECT];

`ifdef CR16_DATAPATH_MUL_EN
    // The low 16 bits of a two's-complement product do not depend on signedness.
    logic [15:0] w_mul;
    assign w_mul = w_a * w_b;
`endif

    always_comb begin
        w_sum = '0;
        w_alu = '0;
        w_c   = 1'b0;
        w_l   = 1'b0;
        w_f   = 1'b0;
        case (op_e'(I_OPCODE))
            OP_ADD: begin
                w_sum = {1'b0, w_a} + {1'b0, w_b};
                w_alu = w_sum[15:0];
                w_f   = (w_a[15] == w_b[15]) && (w_alu[15] != w_a[15]);
            end
            OP_ADDU: begin
                w_sum = {1'b0, w_a} + {1'b0, w_b};
                w_alu = w_sum[15:0];
                w_c   = w_sum[16];
            end
            OP_ADDC: begin
                w_sum = {1'b0, w_a} + {1'b0, w_b} + {16'b0, r_flags[0]};
                w_alu = w_sum[15:0];
                w_f   = (w_a[15] == w_b[15]) && (w_alu[15] != w_a[15]);
            end
            OP_ADDCU: begin
                w_sum = {1'b0, w_a} + {1'b0, w_b} + {16'b0, r_flags[0]};
                w_alu = w_sum[15:0];
                w_c   = w_sum[16];
            end
            OP_SUB: begin
                w_alu = w_a - w_b;
                w_f   = (w_a[15] != w_b[15]) && (w_alu[15] != w_a[15]);
                w_l   = w_a < w_b;
            end
            OP_SUBU: begin
                w_alu = w_a - w_b;
                w_c   = w_a < w_b;
                w_l   = w_a < w_b;
            end
            OP_MUL: begin
`ifdef CR16_DATAPATH_MUL_EN
                w_alu = w_mul;
`else
                w_alu = '0;
`endif
            end
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_NOT:  w_alu = ~w_a;
            OP_LSH:  w_alu = w_a << w_b[3:0];
            OP_RSH:  w_alu = w_a >> w_b[3:0];
            OP_ALSH: w_alu = w_a << w_b[3:0];
            OP_ARSH: w_alu = $signed(w_a) >>> w_b[3:0];
            OP_PASS: w_alu = w_a;
        endcase
    end

    // Flag layout {N, Z, F, L, C}
    assign w_flags  = {w_alu[15], (w_alu == 16'd0), w_f, w_l, w_c};
    assign w_result = I_REGFILE_DATA_SELECT ? I_REGFILE_DATA : w_alu;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= '0;
        end else if (I_ENABLE) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (I_REG_WRITE_ENABLE[i]) begin
                    r_regs[i] <= w_result;
                end
            end
            if (I_STATUS_FLAGS_SELECT) begin
                r_flags <= I_STATUS_FLAGS;
            end else if (!I_REGFILE_DATA_SELECT) begin
                r_flags <= w_flags;
            end
        end
    end

    assign O_A            = w_a;
    assign O_B            = w_b;
    assign O_RESULT_BUS   = w_result;
    assign O_STATUS_FLAGS = r_flags;

endmodule

// File: tb/tb_cr16_datapath.sv
// Self-checking bench for cr16_datapath: vector table plus Fibonacci and reset sequences.
module tb_cr16_datapath;

    logic        I_CLK = 1'b0;
    logic        I_RESET = 1'b0;
    logic        I_ENABLE = 1'b0;
    logic [15:0] I_REG_WRITE_ENABLE = '0;
    logic [3:0]  I_REG_A_SELECT = '0;
    logic [3:0]  I_REG_B_SELECT = '0;
    logic        I_IMMEDIATE_SELECT = 1'b0;
    logic [15:0] I_IMMEDIATE = '0;
    logic [3:0]  I_OPCODE = '0;
    logic [4:0]  I_STATUS_FLAGS = '0;
    logic        I_STATUS_FLAGS_SELECT = 1'b0;
    logic [15:0] I_REGFILE_DATA = '0;
    logic        I_REGFILE_DATA_SELECT = 1'b0;
    logic [15:0] O_A;
    logic [15:0] O_B;
    logic [15:0] O_RESULT_BUS;
    logic [4:0]  O_STATUS_FLAGS;

    cr16_datapath dut (
        .I_CLK                 (I_CLK),
        .I_RESET               (I_RESET),
        .I_ENABLE              (I_ENABLE),
        .I_REG_WRITE_ENABLE    (I_REG_WRITE_ENABLE),
        .I_REG_A_SELECT        (I_REG_A_SELECT),
        .I_REG_B_SELECT        (I_REG_B_SELECT),
        .I_IMMEDIATE_SELECT    (I_IMMEDIATE_SELECT),
        .I_IMMEDIATE           (I_IMMEDIATE),
        .I_OPCODE              (I_OPCODE),
        .I_STATUS_FLAGS        (I_STATUS_FLAGS),
        .I_STATUS_FLAGS_SELECT (I_STATUS_FLAGS_SELECT),
        .I_REGFILE_DATA        (I_REGFILE_DATA),
        .I_REGFILE_DATA_SELECT (I_REGFILE_DATA_SELECT),
        .O_A                   (O_A),
        .O_B                   (O_B),
        .O_RESULT_BUS          (O_RESULT_BUS),
        .O_STATUS_FLAGS        (O_STATUS_FLAGS)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic        en;
        logic [15:0] we;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        isel;
        logic [15:0] imm;
        logic [3:0]  op;
        logic        rfsel;
        logic [15:0] rfd;
        logic        sfsel;
        logic [4:0]  sf;
        logic [15:0] exp_res;
        logic [4:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic en, input logic [15:0] we, input logic [3:0] a,
                                input logic [3:0] b, input logic isel, input logic [15:0] imm,
                                input logic [3:0] op, input logic rfsel, input logic [15:0] rfd,
                                input logic sfsel, input logic [4:0] sf,
                                input logic [15:0] res, input logic [4:0] flags);
        vec_t v;
        v.en = en; v.we = we; v.a = a; v.b = b; v.isel = isel; v.imm = imm; v.op = op;
        v.rfsel = rfsel; v.rfd = rfd; v.sfsel = sfsel; v.sf = sf;
        v.exp_res = res; v.exp_flags = flags;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        I_ENABLE              = v.en;
        I_REG_WRITE_ENABLE    = v.we;
        I_REG_A_SELECT        = v.a;
        I_REG_B_SELECT        = v.b;
        I_IMMEDIATE_SELECT    = v.isel;
        I_IMMEDIATE           = v.imm;
        I_OPCODE              = v.op;
        I_REGFILE_DATA_SELECT = v.rfsel;
        I_REGFILE_DATA        = v.rfd;
        I_STATUS_FLAGS_SELECT = v.sfsel;
        I_STATUS_FLAGS        = v.sf;
    endtask

    // Drive on the falling edge, compare the bus before the rising edge, flags just after it.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t pushed;
        @(negedge I_CLK);
        drive(v);
        pushed.res   = v.exp_res;
        pushed.flags = v.exp_flags;
        sb_q.push_back(pushed);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.queue: got empty expected entry", name);
        end else begin
            e = sb_q.pop_front();
            check({name, ".result"}, {16'h0, O_RESULT_BUS}, {16'h0, e.res});
            @(posedge I_CLK);
            #1;
            check({name, ".flags"}, {27'h0, O_STATUS_FLAGS}, {27'h0, e.flags});
        end
    endtask

    task automatic do_reset();
        @(negedge I_CLK);
        I_RESET = 1'b1;
        @(posedge I_CLK);
        #1;
        @(negedge I_CLK);
        I_RESET = 1'b0;
        drive(mk(1'b1, 16'h0, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, 1'b0, 5'h0, 16'h0, 5'h0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fib [16];
        logic [15:0] mul_res;
        logic [4:0]  mul_flags;

        // Reset must override enable and every write enable
        drive(mk(1'b1, 16'hFFFF, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b1, 16'h1234, 1'b1, 5'h1F, 16'h0, 5'h0));
        @(negedge I_CLK);
        I_RESET = 1'b1;
        @(posedge I_CLK);
        #1;
        @(negedge I_CLK);
        I_RESET = 1'b0;
        drive(mk(1'b1, 16'h0, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, 1'b0, 5'h0, 16'h0, 5'h0));
        #1;
        check("reset.flags", {27'h0, O_STATUS_FLAGS}, 32'h0);
        check("reset.result", {16'h0, O_RESULT_BUS}, 32'h0);

        // Fibonacci chain through r0..r15
        fib[0] = 16'd1;
        fib[1] = 16'd1;
        for (int i = 2; i < 16; i++) fib[i] = fib[i-2] + fib[i-1];
        apply(mk(1'b1, 16'h0003, 4'd0, 4'd0, 1'b1, 16'd1, 4'd0, 1'b0, 16'h0, 1'b0, 5'h0, 16'd1, 5'h0), "fib.load");
        for (int i = 0; i < 14; i++) begin
            apply(mk(1'b1, 16'(1 << (i + 2)), 4'(i), 4'(i + 1), 1'b0, 16'h0, 4'd0, 1'b0, 16'h0,
                     1'b0, 5'h0, fib[i + 2], 5'h0), $sformatf("fib%0d", i));
        end
        check("fib.last", {16'h0, fib[15]}, 32'd987);

        do_reset();

`ifdef CR16_DATAPATH_MUL_EN
        mul_res   = 16'hFFFD;
        mul_flags = 5'h10;
`else
        mul_res   = 16'h0000;
        mul_flags = 5'h08;
`endif
        //               en  we       a     b     isel imm       op     rfsel rfd      sfsel sf     result    flags
        tbl.push_back(mk(1, 16'h0002, 4'd0, 4'd0, 1, 16'h0001, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h0001, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd4,  0, 16'h0000, 0, 5'h00, 16'hFFFF, 5'h12));
        tbl.push_back(mk(1, 16'h0001, 4'd2, 4'd0, 1, 16'h0007, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h0007, 5'h00));
        tbl.push_back(mk(1, 16'h0002, 4'd2, 4'd0, 1, 16'h0004, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h0004, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd7,  0, 16'h0000, 0, 5'h00, 16'h0004, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd8,  0, 16'h0000, 0, 5'h00, 16'h0007, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd9,  0, 16'h0000, 0, 5'h00, 16'h0003, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd10, 0, 16'h0000, 0, 5'h00, 16'hFFF8, 5'h10));
        tbl.push_back(mk(1, 16'h0000, 4'd1, 4'd0, 0, 16'h0000, 4'd5,  0, 16'h0000, 0, 5'h00, 16'hFFFD, 5'h13));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd0, 1, 16'h0014, 4'd11, 0, 16'h0000, 0, 5'h00, 16'h0070, 5'h00));
        tbl.push_back(mk(1, 16'h0008, 4'd2, 4'd0, 1, 16'h8000, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h8000, 5'h10));
        tbl.push_back(mk(1, 16'h0000, 4'd3, 4'd0, 1, 16'h0003, 4'd14, 0, 16'h0000, 0, 5'h00, 16'hF000, 5'h10));
        tbl.push_back(mk(1, 16'h0000, 4'd3, 4'd0, 1, 16'h0003, 4'd12, 0, 16'h0000, 0, 5'h00, 16'h1000, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd0, 1, 16'h0001, 4'd13, 0, 16'h0000, 0, 5'h00, 16'h000E, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd3, 4'd0, 1, 16'h8000, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h0000, 5'h0C));
        tbl.push_back(mk(1, 16'h0010, 4'd2, 4'd0, 1, 16'hFFFF, 4'd0,  0, 16'h0000, 0, 5'h00, 16'hFFFF, 5'h10));
        tbl.push_back(mk(1, 16'h0000, 4'd4, 4'd0, 1, 16'h0001, 4'd1,  0, 16'h0000, 0, 5'h00, 16'h0000, 5'h09));
        tbl.push_back(mk(1, 16'h0000, 4'd2, 4'd0, 1, 16'h0000, 4'd3,  0, 16'h0000, 0, 5'h00, 16'h0001, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd4, 4'd0, 1, 16'h0001, 4'd1,  0, 16'h0000, 0, 5'h00, 16'h0000, 5'h09));
        tbl.push_back(mk(1, 16'h0000, 4'd2, 4'd0, 1, 16'h7FFF, 4'd2,  0, 16'h0000, 0, 5'h00, 16'h8000, 5'h14));
        tbl.push_back(mk(1, 16'h0000, 4'd4, 4'd0, 1, 16'h0003, 4'd6,  0, 16'h0000, 0, 5'h00, mul_res,  mul_flags));
        tbl.push_back(mk(1, 16'h0000, 4'd1, 4'd0, 0, 16'h0000, 4'd15, 0, 16'h0000, 0, 5'h00, 16'h0004, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd2, 4'd0, 1, 16'h0000, 4'd0,  0, 16'h0000, 1, 5'h15, 16'h0000, 5'h15));
        tbl.push_back(mk(1, 16'h0001, 4'd0, 4'd0, 0, 16'h0000, 4'd0,  1, 16'h0005, 0, 5'h00, 16'h0005, 5'h15));
        tbl.push_back(mk(1, 16'h0002, 4'd0, 4'd0, 0, 16'h0000, 4'd0,  1, 16'h0006, 0, 5'h00, 16'h0006, 5'h15));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h000B, 5'h00));
        tbl.push_back(mk(1, 16'h0003, 4'd0, 4'd1, 0, 16'h0000, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h000B, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd0,  0, 16'h0000, 0, 5'h00, 16'h0016, 5'h00));
        tbl.push_back(mk(0, 16'h0004, 4'd0, 4'd0, 0, 16'h0000, 4'd0,  1, 16'h0055, 0, 5'h00, 16'h0055, 5'h00));
        tbl.push_back(mk(1, 16'h0000, 4'd2, 4'd0, 0, 16'h0000, 4'd15, 0, 16'h0000, 0, 5'h00, 16'h0000, 5'h08));
        tbl.push_back(mk(0, 16'h0000, 4'd0, 4'd1, 0, 16'h0000, 4'd0,  0, 16'h0000, 1, 5'h1F, 16'h0016, 5'h08));
        tbl.push_back(mk(0, 16'h0000, 4'd2, 4'd0, 0, 16'h0000, 4'd4,  0, 16'h0000, 0, 5'h00, 16'hFFF5, 5'h08));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset arriving on the same edge as a full-width write must discard that write
        @(negedge I_CLK);
        drive(mk(1'b1, 16'hFFFF, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b1, 16'hABCD, 1'b1, 5'h1F, 16'h0, 5'h0));
        I_RESET = 1'b1;
        @(posedge I_CLK);
        #1;
        @(negedge I_CLK);
        I_RESET = 1'b0;
        check("midreset.flags", {27'h0, O_STATUS_FLAGS}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            drive(mk(1'b0, 16'h0, 4'(i), 4'(i), 1'b0, 16'h0, 4'd15, 1'b0, 16'h0, 1'b0, 5'h0, 16'h0, 5'h0));
            #1;
            check($sformatf("midreset.r%0d", i), {16'h0, O_A}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cr16_datapath.md
CR16_DATAPATH -- requirements
Module: cr16_datapath

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: I_CLK input 1, rising-edge clock; I_RESET input 1, synchronous active-high reset.
REQ-002 SHALL have I_ENABLE input 1: global write/flag-update enable.
REQ-003 SHALL have I_REG_WRITE_ENABLE input 16: one bit per register r0..r15.
REQ-004 SHALL have I_REG_A_SELECT and I_REG_B_SELECT inputs, 4 bits each: register indices for operands A and B.
REQ-005 SHALL have I_IMMEDIATE_SELECT input 1 and I_IMMEDIATE input 16: 1 replaces operand B with I_IMMEDIATE.
REQ-006 SHALL have I_OPCODE input 4: ALU operation.
REQ-007 SHALL have I_STATUS_FLAGS input 5 and I_STATUS_FLAGS_SELECT input 1: external flag load.
REQ-008 SHALL have I_REGFILE_DATA input 16 and I_REGFILE_DATA_SELECT input 1: 1 drives I_REGFILE_DATA onto the result bus.
REQ-009 SHALL have outputs O_A 16 (operand A), O_B 16 (operand B after immediate mux), O_RESULT_BUS 16 (write-back data) and O_STATUS_FLAGS 5 (registered flags, bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N).

Function
REQ-010 SHALL contain sixteen 16-bit registers r0..r15 and a 5-bit status register.
REQ-011 O_A, O_B and O_RESULT_BUS SHALL be combinational from current register contents and inputs: zero-cycle latency.
REQ-012 Operand A = r[I_REG_A_SELECT]; O_B = I_IMMEDIATE_SELECT ? I_IMMEDIATE : r[I_REG_B_SELECT].
REQ-013 ALU ops SHALL be: 0 ADD A+B; 1 ADDU A+B; 2 ADDC A+B+C; 3 ADDCU A+B+C; 4 SUB A-B; 5 SUBU A-B; 6 MUL low 16 bits of signed A*B; 7 AND; 8 OR; 9 XOR; 10 NOT ~A; 11 LSH A<<B[3:0]; 12 RSH A>>B[3:0] logical; 13 ALSH same as LSH; 14 ARSH A>>>B[3:0] sign-filling; 15 pass A. C is the registered carry flag.
REQ-014 All results SHALL wrap modulo 2^16; e.g. SUB 0-1 = 0xFFFF.
REQ-015 O_RESULT_BUS = I_REGFILE_DATA_SELECT ? I_REGFILE_DATA : ALU result.
REQ-016 On each rising edge with I_ENABLE=1 and reset low, every register whose write-enable bit is 1 SHALL load O_RESULT_BUS; multiple set bits write the same value; no bits set means no write.
REQ-017 Writing a register also selected as A or B SHALL take effect only after the edge (read-before-write, no bypass).
REQ-018 Computed flags: C = unsigned carry-out for ADDU/ADDCU, unsigned borrow for SUBU, else 0; F = signed overflow for ADD/ADDC/SUB, else 0; L = 1 if A<B unsigned for SUB/SUBU, else 0; Z = 1 if ALU result is 0; N = ALU result bit 15.
REQ-019 On each rising edge with I_ENABLE=1, the status register SHALL load I_STATUS_FLAGS if I_STATUS_FLAGS_SELECT=1; otherwise it SHALL load the computed flags if I_REGFILE_DATA_SELECT=0; otherwise it SHALL hold.
REQ-020 With I_ENABLE=0, registers and flags SHALL hold; combinational outputs SHALL still track inputs.

Reset
REQ-021 When I_RESET=1 at a rising edge, all registers and status flags SHALL become 0, overriding I_ENABLE and all write enables.
REQ-022 After reset, O_STATUS_FLAGS SHALL be 0; with selects 0 and opcode ADD, O_RESULT_BUS SHALL be 0.
REQ-023 Reset asserted mid-sequence SHALL discard any write pending on that edge.

Configuration
REQ-024 Macro CR16_DATAPATH_MUL_EN SHALL control the multiplier: defined means opcode 6 implements MUL per REQ-013; undefined means opcode 6 yields result 0 with flags computed from that 0 (Z=1), and no multiplier hardware is present.

Verification
REQ-025 Fibonacci: reset; load immediate 1 into r0 and r1; ADD with A=i, B=i+1, write r(i+2) for i=0..13 -> result bus gives 2,3,5,8,...,987 in order.
REQ-026 SUB: reset; r1=1 via immediate; SUB A=r0, B=r1 -> O_RESULT_BUS=0xFFFF; next edge flags N=1, Z=0.
REQ-027 Boolean: r0=7, r1=4 -> AND 4, OR 7, XOR 3, NOT 0xFFF8.
REQ-028 Regfile data: I_REGFILE_DATA_SELECT=1 with data 5 to r0, then 6 to r1 -> bus shows 5 and 6; then ADD r0,r1 -> 11.
REQ-029 Carry: ADDU 0xFFFF+1 -> result 0, next edge C=1, Z=1; following ADDCU 0+0 -> 1.
REQ-030 Enable/reset: I_ENABLE=0 with write enable r2 -> r2 unchanged; I_RESET mid-write -> all registers read 0.
